dac_pll_ctrl: RTL

Supervisor and sequencer for the DAC clock PLL (dac_pll) feeding the I2S transmitter. It generates power-down and reset pulses and qualifies pll_lock with a stability window. It gates the PLL output clocks until lock is trusted, and re-sequences the PLL on lock loss or on a sample-rate change, which reprograms dyn_odiv0. It runs on the free-running 50 MHz board clock that also drives clkin1.

---
 rtl/dac_pll_pkg.sv | 19 +
 rtl/sync_2ff.sv | 22 ++
 rtl/dac_pll_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dac_pll_pkg.sv
// Shared constants and types for the DAC clock PLL supervisor.
package dac_pll_pkg;

    // Free-running board clock that also feeds clkin1.
    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [2:0] {
        PWD       = 3'd0,
        RST       = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_state_e;

    // clkout0 divider per sample-rate index (rate_sel).
    localparam logic [9:0] ODIV_TBL [0:3] = '{10'd100, 10'd50, 10'd200, 10'd25};

endpackage

// File: rtl/sync_2ff.sv
// Reusable single-bit two-flop synchronizer.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dac_pll_ctrl.sv
// DAC PLL supervisor: power/reset sequencing, lock qualification,
// output gating, lock-loss recovery and sample-rate reprogramming.
module dac_pll_ctrl
    import dac_pll_pkg::*;
#(
    parameter int unsigned PWD_CYC      = 16,
    parameter int unsigned RST_CYC      = 16,
    parameter int unsigned LOCK_TIMEOUT = CLK_HZ / 1000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       rate_req,
    input  logic [1:0] rate_sel,
    input  logic       fault_clr,
    output logic       pll_pwd,
    output logic       pll_rst,
    output logic       rstodiv,
    output logic [9:0] dyn_odiv0,
    output logic       clkout_gate,
    output logic       clk_ready,
    output logic       rate_ack,
    output logic       fault,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    localparam int unsigned T_A  = (PWD_CYC > RST_CYC) ? PWD_CYC : RST_CYC;
    localparam int unsigned T_B  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int unsigned TMAX = (T_A > T_B) ? T_A : T_B;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned RW   = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

    pll_state_e     state_q, nxt;
    logic [TW-1:0]  tmr, tmr_n;
    logic [RW-1:0]  retry, retry_n, retry_inc;
    logic [1:0]     cur_sel, sel_n;
    logic [9:0]     odiv_n;
    logic [7:0]     loss_n;
    logic           ack_pend, pend_n, ack_n;
    logic           lock_s, req_ok;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign state     = state_q;
    assign retry_inc = retry + RW'(1);

    // Next-state and datapath decisions; the timer restarts on every transition.
    always_comb begin
        nxt     = state_q;
        tmr_n   = '0;
        retry_n = retry;
        sel_n   = cur_sel;
        odiv_n  = dyn_odiv0;
        pend_n  = ack_pend;
        loss_n  = lock_loss_cnt;
        ack_n   = 1'b0;
        // A request still held in the ack cycle is the old one, not a new one.
        req_ok  = rate_req && !rate_ack;
        case (state_q)
            PWD: begin
                if (tmr == TW'(PWD_CYC - 1)) nxt = RST;
                else                         tmr_n = tmr + TW'(1);
            end
            RST: begin
                if (tmr == TW'(RST_CYC - 1)) nxt = WAIT_LOCK;
                else                         tmr_n = tmr + TW'(1);
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt = STABLE;
                end else if (tmr == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_n = retry_inc;
                    if (retry_inc == RW'(MAX_RETRY)) begin
                        nxt    = FAULT;
                        pend_n = 1'b0;
                    end else begin
                        nxt = RST;
                    end
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    nxt = WAIT_LOCK;
                end else if (tmr == TW'(LOCK_STABLE - 1)) begin
                    nxt     = RUN;
                    retry_n = '0;
                    if (ack_pend) begin
                        ack_n  = 1'b1;
                        pend_n = 1'b0;
                    end
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    if (lock_loss_cnt != 8'hFF) loss_n = lock_loss_cnt + 8'd1;
                    nxt = RST;
                end
                // Lock loss and rate change share one RST sequence.
                if (req_ok) begin
                    if (rate_sel == cur_sel) begin
                        if (lock_s) ack_n  = 1'b1;
                        else        pend_n = 1'b1;
                    end else begin
                        sel_n  = rate_sel;
                        odiv_n = ODIV_TBL[rate_sel];
                        pend_n = 1'b1;
                        nxt    = RST;
                    end
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    nxt     = PWD;
                    retry_n = '0;
                end
            end
            default: nxt = PWD;
        endcase
    end

    // State/datapath registers; outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PWD;
            tmr           <= '0;
            retry         <= '0;
            cur_sel       <= '0;
            ack_pend      <= 1'b0;
            lock_loss_cnt <= '0;
            dyn_odiv0     <= ODIV_TBL[0];
            pll_pwd       <= 1'b1;
            pll_rst       <= 1'b1;
            rstodiv       <= 1'b1;
            clkout_gate   <= 1'b1;
            clk_ready     <= 1'b0;
            rate_ack      <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_q       <= nxt;
            tmr           <= tmr_n;
            retry         <= retry_n;
            cur_sel       <= sel_n;
            ack_pend      <= pend_n;
            lock_loss_cnt <= loss_n;
            dyn_odiv0     <= odiv_n;
            pll_pwd       <= (nxt == PWD) || (nxt == FAULT);
            pll_rst       <= (nxt == PWD) || (nxt == RST) || (nxt == FAULT);
            rstodiv       <= (nxt != RUN);
            clkout_gate   <= (nxt != RUN);
            clk_ready     <= (nxt == RUN);
            rate_ack      <= ack_n;
            fault         <= (nxt == FAULT);
        end
    end

endmodule
